lcd_hd44780_writer: RTL and testbench

//  Drives an HD44780-class character LCD over its 8-bit parallel bus. Runs on clk_in (50 MHz).

---
 rtl/lcd_hd44780_writer_if.sv | 22 ++
 rtl/lcd_hd44780_writer.sv | 194 +++++++++++++++++++
 tb/tb_lcd_hd44780_writer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_writer_if.sv
// Byte stream feeding the HD44780 writer: one command/data byte per valid/ready handshake.
// The master is the upstream producer; the slave is the LCD writer.
interface lcd_hd44780_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;

    modport master (
        output in_valid,
        output in_rs,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_rs,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/lcd_hd44780_writer.sv
// HD44780 8-bit parallel bus writer: fixed power-up init sequence, then streamed cmd/data bytes.
// Bus transactions are spaced by waits counted in transitions of the 40 us reference wave.
module lcd_hd44780_writer #(
    parameter int unsigned PWRUP_TICKS = 500,
    parameter int unsigned INIT_TICKS  = 110,
    parameter int unsigned CMD_TICKS   = 2,
    parameter int unsigned CLR_TICKS   = 50,
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned EN_CYC      = 25,
    parameter int unsigned HOLD_CYC    = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_n,
    input  logic                       tick_clk,
    lcd_hd44780_writer_if.slave        in_bus,
    output logic                       init_done,
    output logic                       busy,
    output logic                       lcd_rs,
    output logic                       lcd_rw,
    output logic                       lcd_en,
    output logic [7:0]                 lcd_data
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_LOAD,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } state_t;

    localparam logic [15:0] PWRUP_LAST = 16'(PWRUP_TICKS - 1);
    localparam logic [15:0] INIT_LAST  = 16'(INIT_TICKS - 1);
    localparam logic [15:0] CMD_LAST   = 16'(CMD_TICKS - 1);
    localparam logic [15:0] CLR_LAST   = 16'(CLR_TICKS - 1);
    localparam logic [7:0]  SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0]  EN_LAST    = 8'(EN_CYC - 1);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYC - 1);
    localparam logic [2:0]  INIT_LAST_IDX = 3'd5;

    state_t      state;
    logic        tick_prev;
    logic        tick_primed;
    logic        tick;
    logic [15:0] tick_cnt;
    logic [15:0] wait_last;
    logic [7:0]  cyc_cnt;
    logic [2:0]  init_idx;
    logic        in_init;
    logic        is_clear;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h38;
            3'd1:    b = 8'h38;
            3'd2:    b = 8'h38;
            3'd3:    b = 8'h0C;
            3'd4:    b = 8'h01;
            default: b = 8'h06;
        endcase
        return b;
    endfunction

    // tick_clk is only sampled; the first cycle after reset just loads tick_prev.
    assign tick     = tick_primed && (tick_clk != tick_prev);
    assign is_clear = !lcd_rs && (lcd_data[7:2] == 6'd0) && (lcd_data[1:0] != 2'd0);
    assign lcd_rw   = 1'b0;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_prev   <= 1'b0;
            tick_primed <= 1'b0;
        end else begin
            tick_prev   <= tick_clk;
            tick_primed <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_PWRUP;
            tick_cnt        <= 16'd0;
            wait_last       <= 16'd0;
            cyc_cnt         <= 8'd0;
            init_idx        <= 3'd0;
            in_init         <= 1'b0;
            init_done       <= 1'b0;
            busy            <= 1'b0;
            in_bus.in_ready <= 1'b0;
            lcd_rs          <= 1'b0;
            lcd_en          <= 1'b0;
            lcd_data        <= 8'd0;
        end else begin
            case (state)
                S_PWRUP: begin
                    busy <= 1'b1;
                    if (tick) begin
                        if (tick_cnt >= PWRUP_LAST) begin
                            tick_cnt <= 16'd0;
                            init_idx <= 3'd0;
                            in_init  <= 1'b1;
                            state    <= S_LOAD;
                        end else begin
                            tick_cnt <= tick_cnt + 16'd1;
                        end
                    end
                end

                S_LOAD: begin
                    lcd_rs   <= 1'b0;
                    lcd_data <= init_byte(init_idx);
                    cyc_cnt  <= 8'd0;
                    state    <= S_SETUP;
                end

                S_SETUP: begin
                    if (cyc_cnt >= SETUP_LAST) begin
                        cyc_cnt <= 8'd0;
                        lcd_en  <= 1'b1;
                        state   <= S_PULSE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end

                S_PULSE: begin
                    if (cyc_cnt >= EN_LAST) begin
                        cyc_cnt <= 8'd0;
                        lcd_en  <= 1'b0;
                        state   <= S_HOLD;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end

                S_HOLD: begin
                    if (cyc_cnt >= HOLD_LAST) begin
                        cyc_cnt  <= 8'd0;
                        tick_cnt <= 16'd0;
                        // First function-set and clear/home need the long execution times.
                        if (in_init && init_idx == 3'd0) begin
                            wait_last <= INIT_LAST;
                        end else if (is_clear) begin
                            wait_last <= CLR_LAST;
                        end else begin
                            wait_last <= CMD_LAST;
                        end
                        state <= S_WAIT;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end

                S_WAIT: begin
                    if (tick) begin
                        if (tick_cnt >= wait_last) begin
                            if (in_init && init_idx != INIT_LAST_IDX) begin
                                init_idx <= init_idx + 3'd1;
                                state    <= S_LOAD;
                            end else begin
                                in_init         <= 1'b0;
                                init_done       <= 1'b1;
                                busy            <= 1'b0;
                                in_bus.in_ready <= 1'b1;
                                state           <= S_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 16'd1;
                        end
                    end
                end

                S_IDLE: begin
                    if (in_bus.in_valid && in_bus.in_ready) begin
                        lcd_rs          <= in_bus.in_rs;
                        lcd_data        <= in_bus.in_data;
                        in_bus.in_ready <= 1'b0;
                        busy            <= 1'b1;
                        cyc_cnt         <= 8'd0;
                        state           <= S_SETUP;
                    end
                end

                default: begin
                    state <= S_PWRUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Scoreboard bench: every byte expected on the LCD bus is queued when issued; a monitor
// pops and checks it at each EN rising edge, along with pulse width, setup and hold.
module tb_lcd_hd44780_writer;

    logic       clk_in;
    logic       rst_n;
    logic       tick_clk;
    logic       init_done;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    lcd_hd44780_writer_if bus ();

    lcd_hd44780_writer #(
        .PWRUP_TICKS (4),
        .INIT_TICKS  (3),
        .CMD_TICKS   (2),
        .CLR_TICKS   (5),
        .SETUP_CYC   (4),
        .EN_CYC      (25),
        .HOLD_CYC    (4)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .tick_clk  (tick_clk),
        .in_bus    (bus),
        .init_done (init_done),
        .busy      (busy),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         n_pushed = 0;
    int         n_pulses = 0;
    logic [8:0] exp_q[$];

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // 40 us reference scaled to 200 clocks per half period, changed on falling edges.
    initial begin
        tick_clk = 1'b0;
        forever begin
            repeat (200) @(negedge clk_in);
            tick_clk <= ~tick_clk;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        n_vec++;
        if (actual < lo || actual > hi) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        n_pushed += 6;
    endtask

    task automatic check_reset_outputs(input string name);
        check_output(name, 32'({busy, init_done, bus.in_ready, lcd_en, lcd_rs, lcd_rw, lcd_data}),
                     32'd0);
    endtask

    // Release reset and count reference transitions until the first EN pulse.
    task automatic release_and_measure();
        int   trans;
        int   guard;
        logic prev;
        prev  = tick_clk;
        trans = 0;
        rst_n = 1'b1;
        @(negedge clk_in);
        check_output("busy_after_release", busy, 1);
        guard = 0;
        while (!lcd_en && guard < 5000) begin
            if (tick_clk !== prev) begin
                trans++;
                prev = tick_clk;
            end
            @(negedge clk_in);
            guard++;
        end
        check_output("pwrup_first_pulse", lcd_en, 1);
        check_output("pwrup_transitions", trans, 4);
    endtask

    task automatic wait_init_done();
        int guard;
        guard = 0;
        while (!init_done && guard < 20000) begin
            @(negedge clk_in);
            guard++;
        end
        check_output("init_done", init_done, 1);
        check_output("ready_after_init", bus.in_ready, 1);
        check_output("idle_not_busy", busy, 0);
    endtask

    // Offer one byte, wait for acceptance, then time how long in_ready stays low.
    task automatic apply_stimulus(input logic rs, input logic [7:0] d, input int n_ticks);
        int guard;
        int low;
        bus.in_valid = 1'b1;
        bus.in_rs    = rs;
        bus.in_data  = d;
        guard = 0;
        while (!bus.in_ready && guard < 5000) begin
            @(negedge clk_in);
            guard++;
        end
        check_output("accept_ready", bus.in_ready, 1);
        if (!bus.in_ready) return;
        exp_q.push_back({rs, d});
        n_pushed++;
        @(negedge clk_in);
        low = 0;
        while (!bus.in_ready && low < 3000) begin
            low++;
            @(negedge clk_in);
        end
        check_range($sformatf("ready_low_%0d_%02h", rs, d), low,
                    33 + (n_ticks - 1) * 200, 33 + n_ticks * 200 + 4);
    endtask

    // Monitor: compares each EN pulse against the scoreboard queue.
    initial begin
        logic       en_prev;
        int         width;
        int         stable;
        int         hold_left;
        logic [8:0] cur;
        logic [8:0] prev_bus;
        logic [8:0] hold_snap;
        logic [8:0] e;
        en_prev   = 1'b0;
        width     = 0;
        stable    = 0;
        hold_left = 0;
        prev_bus  = 9'd0;
        hold_snap = 9'd0;
        forever begin
            @(negedge clk_in);
            cur = {lcd_rs, lcd_data};
            if (!rst_n) begin
                en_prev   = 1'b0;
                width     = 0;
                stable    = 0;
                hold_left = 0;
                prev_bus  = cur;
            end else begin
                if (lcd_en && !en_prev) begin
                    n_pulses++;
                    check_range("setup_cycles", stable, 4, 1000000);
                    check_range("pulse_expected", exp_q.size(), 1, 1000);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_output("pulse_bus", 32'(cur), 32'(e));
                    end
                    width = 1;
                end else if (lcd_en) begin
                    width++;
                end else if (en_prev) begin
                    check_output("en_width", width, 25);
                    hold_left = 4;
                    hold_snap = cur;
                end else if (hold_left > 0) begin
                    hold_left--;
                    if (hold_left == 0) check_output("hold_bus", 32'(cur), 32'(hold_snap));
                end
                if (!lcd_en) stable = (cur != prev_bus) ? 1 : stable + 1;
                prev_bus = cur;
                en_prev  = lcd_en;
            end
        end
    end

    initial begin
        int guard;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_rs    = 1'b0;
        bus.in_data  = 8'd0;
        repeat (3) @(negedge clk_in);
        check_reset_outputs("reset_outputs");
        check_output("rw_low", lcd_rw, 0);

        $display("[TB] init sequence after first reset");
        push_init();
        release_and_measure();
        wait_init_done();

        $display("[TB] data and command writes");
        apply_stimulus(1'b1, 8'h41, 2);
        apply_stimulus(1'b0, 8'h01, 5);
        apply_stimulus(1'b0, 8'h80, 2);
        apply_stimulus(1'b0, 8'h03, 5);
        apply_stimulus(1'b0, 8'h04, 2);
        apply_stimulus(1'b0, 8'h00, 2);
        apply_stimulus(1'b1, 8'h01, 2);
        bus.in_valid = 1'b0;

        $display("[TB] back-to-back bytes");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 8'(8'h30 + i), 2);
        end
        bus.in_valid = 1'b0;
        check_output("queue_drained", exp_q.size(), 0);

        $display("[TB] reset during EN pulse");
        bus.in_valid = 1'b1;
        bus.in_rs    = 1'b1;
        bus.in_data  = 8'h55;
        exp_q.push_back({1'b1, 8'h55});
        n_pushed++;
        @(negedge clk_in);
        bus.in_valid = 1'b0;
        guard = 0;
        while (!lcd_en && guard < 100) begin
            @(negedge clk_in);
            guard++;
        end
        check_output("abort_pulse_start", lcd_en, 1);
        repeat (5) @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1 check_output("abort_en_low", lcd_en, 0);
        check_reset_outputs("abort_reset_outputs");

        guard = 0;
        while (tick_clk !== 1'b1 && guard < 1000) begin
            @(negedge clk_in);
            guard++;
        end
        repeat (10) @(negedge clk_in);
        check_reset_outputs("reset_held_outputs");

        $display("[TB] init replay with tick_clk high at release");
        exp_q.delete();
        push_init();
        release_and_measure();
        wait_init_done();
        apply_stimulus(1'b1, 8'h7A, 2);
        bus.in_valid = 1'b0;

        check_output("queue_empty_end", exp_q.size(), 0);
        check_output("pulse_count", n_pulses, n_pushed);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
